uart_rcvr_fifo: RTL and testbench

UART_RCVR_FIFO -- requirements
Module: uart_rcvr_fifo

---
 rtl/uart_rcvr_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rcvr_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcvr_fifo.sv
// UART receiver with mid-bit sampling, framing/parity checks and a show-ahead receive FIFO.
// Optional parity stage is compiled in when the macro UART_RCVR_PARITY_EN is defined.
module uart_rcvr_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uart_sin,
    input  logic                          uart_msgon,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RCVR_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_sinMeta;
    logic                   r_sinSync;
    logic                   r_sinPrev;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_bitCnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_capture;
    logic                   r_pushReq;
    logic                   r_framingErr;
    logic                   r_overrun;
    logic                   w_tick;
    logic                   w_framingSet;
    logic                   w_goodFrame;
    logic                   w_parFail;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wrPtr;
    logic [AW-1:0]          r_rdPtr;
    logic [AW:0]            r_count;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;

`ifdef UART_RCVR_PARITY_EN
    logic                   r_parFail;
    logic                   r_parityErr;
    logic                   w_parSet;
    assign w_parFail  = r_parFail;
    assign parity_err = r_parityErr;
`else
    assign w_parFail  = 1'b0;
    assign parity_err = PAR_ODD & 1'b0;
`endif

    assign w_tick = (r_cnt == '0);

    // Parks in BREAK out of reset so a line that is still low cannot fake a start bit.
    always_ff @(posedge clock) begin
        if (reset) r_state <= BREAK;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_framingSet = 1'b0;
        w_goodFrame  = 1'b0;
`ifdef UART_RCVR_PARITY_EN
        w_parSet     = 1'b0;
`endif
        case (r_state)
            IDLE:  if (r_sinPrev && !r_sinSync) w_next = START;
            START: if (w_tick) w_next = r_sinSync ? IDLE : DATA;
            DATA: begin
                if (w_tick && (r_bitCnt == 4'(DATA_BITS - 1))) begin
`ifdef UART_RCVR_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef UART_RCVR_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_next   = STOP;
                    w_parSet = (((^r_shift) ^ r_sinSync) != PAR_ODD);
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (!r_sinSync) begin
                        w_next       = BREAK;
                        w_framingSet = !w_parFail;
                    end else if (r_bitCnt == 4'(STOP_BITS - 1)) begin
                        w_next      = IDLE;
                        w_goodFrame = !w_parFail;
                    end
                end
            end
            BREAK: if (r_sinSync) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bit timing, data shifting and error/push strobes; a parity failure suppresses later pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sinMeta    <= 1'b1;
            r_sinSync    <= 1'b1;
            r_sinPrev    <= 1'b1;
            r_cnt        <= '0;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_capture    <= 1'b0;
            r_pushReq    <= 1'b0;
            r_framingErr <= 1'b0;
`ifdef UART_RCVR_PARITY_EN
            r_parFail    <= 1'b0;
            r_parityErr  <= 1'b0;
`endif
        end else begin
            r_sinMeta    <= uart_sin;
            r_sinSync    <= r_sinMeta;
            r_sinPrev    <= r_sinSync;
            r_pushReq    <= w_goodFrame && r_capture;
            r_framingErr <= w_framingSet;
`ifdef UART_RCVR_PARITY_EN
            r_parityErr  <= w_parSet;
            if (w_parSet) r_parFail <= 1'b1;
`endif
            if (r_state == IDLE && w_next == START) begin
                r_cnt     <= HALF_BIT;
                r_capture <= uart_msgon;
`ifdef UART_RCVR_PARITY_EN
                r_parFail <= 1'b0;
`endif
            end else if (w_tick) begin
                r_cnt <= FULL_BIT;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_tick) begin
                if (w_next != r_state) r_bitCnt <= '0;
                else                   r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (r_state == DATA && w_tick) r_shift <= {r_sinSync, r_shift[DATA_BITS-1:1]};
        end
    end

    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = rx_valid && rx_ready;
    assign w_push     = r_pushReq && (!w_full || w_pop);
    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? r_mem[r_rdPtr] : '0;
    assign fifo_count = r_count;
    assign framing_err = r_framingErr;
    assign overrun    = r_overrun;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wrPtr] <= r_shift;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_pushReq && w_full && !w_pop;
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rcvr_fifo.sv
// Bench for uart_rcvr_fifo: directed frame scenarios plus randomized frames checked against a byte-queue model.
// Instance A uses 8 data bits/1 stop, instance B 9 data bits/2 stops; both use a 4-entry FIFO.
module tb_uart_rcvr_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sinA = 1'b1, sinB = 1'b1, msgon = 1'b1, readyA = 1'b0, readyB = 1'b0;
    logic [7:0] dataA;
    logic [8:0] dataB;
    logic       validA, validB, fA, pA, oA, fB, pB, oB;
    logic [2:0] countA, countB;

    int tests = 0, failed = 0;
    int fErrA = 0, pErrA = 0, oErrA = 0, fErrB = 0, pErrAll = 0, validCyc = 0;
    logic [7:0] lastA = 8'h00;
    bit modelOn = 1'b0, settled = 1'b0;
    logic [7:0] q[$];
`ifdef UART_RCVR_PARITY_EN
    bit badParity = 1'b0;
`endif

    uart_rcvr_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dutA (
        .clock(clock), .reset(reset), .uart_sin(sinA), .uart_msgon(msgon),
        .rx_data(dataA), .rx_valid(validA), .rx_ready(readyA), .fifo_count(countA),
        .framing_err(fA), .parity_err(pA), .overrun(oA));

    uart_rcvr_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dutB (
        .clock(clock), .reset(reset), .uart_sin(sinB), .uart_msgon(msgon),
        .rx_data(dataB), .rx_valid(validB), .rx_ready(readyB), .fifo_count(countB),
        .framing_err(fB), .parity_err(pB), .overrun(oB));

    always #5 clock = ~clock;

    // Pulse and valid-cycle tallies, sampled on the falling edge.
    always @(negedge clock) begin
        if (fA) fErrA++;
        if (pA) pErrA++;
        if (oA) oErrA++;
        if (fB) fErrB++;
        if (pA || pB) pErrAll++;
        if (validA) begin
            validCyc++;
            lastA = dataA;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every-cycle comparison against the byte-queue model during the random phase.
    always @(negedge clock) begin
        if (modelOn && !reset) begin
            if (settled) begin
                checkOutput("cmpCount", int'(countA), q.size());
                checkOutput("cmpValid", int'(validA), int'(q.size() != 0));
                if (q.size() != 0) checkOutput("cmpHead", int'(dataA), int'(q[0]));
                else               checkOutput("cmpEmptyData", int'(dataA), 0);
            end else if (validA && q.size() != 0) begin
                checkOutput("cmpHeadBusy", int'(dataA), int'(q[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setLine(input int sel, input logic v);
        if (sel == 0) sinA = v;
        else          sinB = v;
    endtask

    task automatic idle(input int n);
        sinA = 1'b1;
        sinB = 1'b1;
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input int sel, input logic [8:0] data, input int nbits,
                                 input int nstop, input logic lastStop);
        logic par;
        par = 1'b0;
        setLine(sel, 1'b0);
        repeat (CPB) tick();
        for (int i = 0; i < nbits; i++) begin
            par = par ^ data[i];
            setLine(sel, data[i]);
            repeat (CPB) tick();
        end
`ifdef UART_RCVR_PARITY_EN
        setLine(sel, par ^ badParity);
        repeat (CPB) tick();
`endif
        for (int i = 0; i < nstop; i++) begin
            setLine(sel, (i == nstop - 1) ? lastStop : 1'b1);
            repeat (CPB) tick();
        end
        setLine(sel, 1'b1);
    endtask

    initial begin
        int bf, bo, bp, nGap;
        bit ferr;
        logic [7:0] d;

        repeat (3) tick();
        checkOutput("rstCount", int'(countA), 0);
        checkOutput("rstValid", int'(validA), 0);
        checkOutput("rstData", int'(dataA), 0);
        checkOutput("rstErrors", int'({fA, pA, oA}), 0);
        reset = 1'b0;
        idle(4);
        checkOutput("postRstCount", int'(countA), 0);
        checkOutput("postRstCountB", int'(countB), 0);

        // Single frame with the consumer always ready.
        readyA = 1'b1;
        bp = validCyc; bf = fErrA; bo = oErrA;
        applyStimulus(0, 9'h055, 8, 1, 1'b1);
        idle(6);
        checkOutput("r034ValidCycles", validCyc - bp, 1);
        checkOutput("r034Data", int'(lastA), 8'h55);
        checkOutput("r034NoPulse", (fErrA - bf) + (oErrA - bo), 0);
        readyA = 1'b0;

        // Framing error, long break, then a clean frame.
        bf = fErrA;
        applyStimulus(0, 9'h0A3, 8, 1, 1'b0);
        sinA = 1'b0;
        repeat (40 * CPB) tick();
        idle(10);
        checkOutput("r035FramingPulse", fErrA - bf, 1);
        checkOutput("r035NoPush", int'(countA), 0);
        applyStimulus(0, 9'h03C, 8, 1, 1'b1);
        idle(6);
        checkOutput("r035Count", int'(countA), 1);
        checkOutput("r035Data", int'(dataA), 8'h3C);
        checkOutput("r035OnePulse", fErrA - bf, 1);
        readyA = 1'b1; tick(); readyA = 1'b0;
        checkOutput("r035Drained", int'(countA), 0);

        // Overrun on the fifth byte into a four-entry FIFO.
        bo = oErrA;
        for (int v = 1; v <= 5; v++) begin
            applyStimulus(0, 9'(v), 8, 1, 1'b1);
            idle(6);
        end
        checkOutput("r036Overrun", oErrA - bo, 1);
        checkOutput("r036Count", int'(countA), 4);
        for (int v = 1; v <= 4; v++) begin
            checkOutput("r036Drain", int'(dataA), v);
            readyA = 1'b1; tick(); readyA = 1'b0;
        end
        checkOutput("r036Empty", int'(countA), 0);

        // Short glitch, then reset in the middle of a frame.
        bf = fErrA; bo = oErrA;
        sinA = 1'b0;
        repeat (4) tick();
        idle(20);
        checkOutput("r037GlitchCount", int'(countA), 0);
        checkOutput("r037GlitchPulse", (fErrA - bf) + (oErrA - bo), 0);
        setLine(0, 1'b0); repeat (CPB) tick();
        setLine(0, 1'b0); repeat (CPB) tick();
        setLine(0, 1'b1); repeat (CPB) tick();
        setLine(0, 1'b1); repeat (CPB) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        idle(6);
        checkOutput("r037RstCount", int'(countA), 0);
        applyStimulus(0, 9'h081, 8, 1, 1'b1);
        idle(6);
        checkOutput("r037Count", int'(countA), 1);
        checkOutput("r037Data", int'(dataA), 8'h81);
        checkOutput("r037NoPulse", (fErrA - bf) + (oErrA - bo), 0);
        readyA = 1'b1; tick(); readyA = 1'b0;

`ifdef UART_RCVR_PARITY_EN
        bp = pErrA;
        badParity = 1'b1;
        applyStimulus(0, 9'h001, 8, 1, 1'b1);
        badParity = 1'b0;
        idle(6);
        checkOutput("r038ParityPulse", pErrA - bp, 1);
        checkOutput("r038NoPush", int'(countA), 0);
        applyStimulus(0, 9'h003, 8, 1, 1'b1);
        idle(6);
        checkOutput("r038Count", int'(countA), 1);
        checkOutput("r038Data", int'(dataA), 8'h03);
        readyA = 1'b1; tick(); readyA = 1'b0;
`endif

        // Nine data bits with two stop bits on instance B.
        bf = fErrB;
        applyStimulus(1, 9'h1FF, 9, 2, 1'b0);
        idle(10);
        checkOutput("r039FramingPulse", fErrB - bf, 1);
        checkOutput("r039NoPush", int'(countB), 0);
        applyStimulus(1, 9'h155, 9, 2, 1'b1);
        idle(6);
        checkOutput("r039Count", int'(countB), 1);
        checkOutput("r039Data", int'(dataB), 9'h155);
        readyB = 1'b1; tick(); readyB = 1'b0;

        // Randomized frames against the queue model.
        modelOn = 1'b1;
        settled = 1'b1;
        tick();
        for (int n = 0; n < 40; n++) begin
            settled = 1'b0;
            readyA  = 1'b0;
            ferr    = ($urandom_range(0, 9) < 2);
            msgon   = ferr ? 1'b1 : ($urandom_range(0, 3) != 0);
            d       = 8'($urandom_range(0, 255));
            bf = fErrA; bo = oErrA;
            applyStimulus(0, {1'b0, d}, 8, 1, !ferr);
            repeat (4) tick();
            bp = 0;
            if (!ferr && msgon) begin
                if (q.size() < DEPTH) q.push_back(d);
                else                  bp = 1;
            end
            checkOutput("rndFraming", fErrA - bf, int'(ferr));
            checkOutput("rndOverrun", oErrA - bo, bp);
            settled = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                sinA = 1'b0;
                repeat (4) tick();
                sinA = 1'b1;
            end
            nGap = $urandom_range(16, 40);
            for (int c = 0; c < nGap; c++) begin
                readyA = ($urandom_range(0, 5) == 0);
                tick();
                if (readyA && q.size() != 0) void'(q.pop_front());
            end
            readyA = 1'b0;
        end
        readyA = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (q.size() != 0) void'(q.pop_front());
        end
        readyA = 1'b0;
        tick();
        checkOutput("finalCount", int'(countA), 0);
        modelOn = 1'b0;
        msgon = 1'b1;

`ifndef UART_RCVR_PARITY_EN
        checkOutput("parityTiedLow", pErrAll, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
